bank_req_arb_varlat: RTL and testbench

- Per-bank request arbiter and response router for the variable-latency TCDM crossbar.
- Sits directly downstream of the master-side address decoder / response mux stages. Input j connects to bit k of master j's decoded request vector for bank k.
- Arbitrates NumIn masters round-robin onto one variable-latency bank port.
- Records the granted master index in an in-order ID FIFO, so the bank's later valid/rdata response returns to the correct master.

---
 rtl/bank_req_arb_varlat.sv | 110 +++++++++++
 tb/tb_bank_req_arb_varlat.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bank_req_arb_varlat.sv
// Per-bank round-robin request arbiter with an in-order ID FIFO that routes
// variable-latency bank responses back to the master that issued them.
module bank_req_arb_varlat #(
  parameter int unsigned NumIn          = 4,
  parameter int unsigned ReqDataWidth   = 32,
  parameter int unsigned RespDataWidth  = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NumIn-1:0]                       req_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]     data_i,
  output logic [NumIn-1:0]                       gnt_o,
  output logic [NumIn-1:0]                       vld_o,
  output logic [NumIn-1:0][RespDataWidth-1:0]    rdata_o,
  output logic                                   req_o,
  output logic [ReqDataWidth-1:0]                data_o,
  input  logic                                   gnt_i,
  input  logic                                   vld_i,
  input  logic [RespDataWidth-1:0]               rdata_i
);

  localparam int unsigned PtrW     = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned FifoPtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);

  localparam logic [PtrW-1:0]     LastIn   = PtrW'(NumIn - 1);
  localparam logic [FifoPtrW-1:0] LastSlot = FifoPtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0]     Depth    = CntW'(MaxOutstanding);

  if (NumIn < 2 || MaxOutstanding == 0) begin : g_param_err
    $fatal(1, "bank_req_arb_varlat: need NumIn>=2 and MaxOutstanding>=1");
  end

  logic [PtrW-1:0]     rr_ptr;
  logic [PtrW-1:0]     winner;
  logic [PtrW-1:0]     id_mem [MaxOutstanding];
  logic [FifoPtrW-1:0] wr_ptr;
  logic [FifoPtrW-1:0] rd_ptr;
  logic [CntW-1:0]     count;
  logic [PtrW-1:0]     head;
  logic                accept_ok;
  logic                push;
  logic                pop;
  logic                found;
  int unsigned         idx;

  // Round-robin search starting at rr_ptr; falls back to rr_ptr when idle.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      idx = (32'(rr_ptr) + i) % NumIn;
      if (!found && req_i[PtrW'(idx)]) begin
        winner = PtrW'(idx);
        found  = 1'b1;
      end
    end
  end

  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign accept_ok = (count < Depth) | vld_i;
  assign req_o     = (|req_i) & accept_ok;
  assign data_o    = data_i[winner];
  assign push      = req_o & gnt_i;
  assign pop       = vld_i & (count != '0);
  assign head      = id_mem[rd_ptr];
  assign rdata_o   = {NumIn{rdata_i}};

  always_comb begin
    gnt_o = '0;
    vld_o = '0;
    if (push) gnt_o[winner] = 1'b1;
    if (pop)  vld_o[head]   = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        rr_ptr <= (winner == LastIn) ? '0 : winner + PtrW'(1);
        wr_ptr <= (wr_ptr == LastSlot) ? '0 : wr_ptr + FifoPtrW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LastSlot) ? '0 : rd_ptr + FifoPtrW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // ID storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr] <= winner;
  end

  // A response with nothing outstanding is dropped; flag it in simulation.
  resp_without_id : assert property (@(posedge clk_i) disable iff (rst_i)
                                     !(vld_i && count == '0))
    else $warning("bank_req_arb_varlat: response with no outstanding ID dropped");

endmodule

// File: tb/tb_bank_req_arb_varlat.sv
// Directed bench for bank_req_arb_varlat: round-robin order, ID routing,
// outstanding limit, grant stall and reset flush.
module tb_bank_req_arb_varlat;

  localparam int unsigned NumIn = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned RW    = 32;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic [NumIn-1:0]           req_i;
  logic [NumIn-1:0][DW-1:0]   data_i;
  logic [NumIn-1:0]           gnt_o;
  logic [NumIn-1:0]           vld_o;
  logic [NumIn-1:0][RW-1:0]   rdata_o;
  logic                       req_o;
  logic [DW-1:0]              data_o;
  logic                       gnt_i;
  logic                       vld_i;
  logic [RW-1:0]              rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  bank_req_arb_varlat #(
    .NumIn(NumIn), .ReqDataWidth(DW), .RespDataWidth(RW), .MaxOutstanding(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
    .gnt_o(gnt_o), .vld_o(vld_o), .rdata_o(rdata_o), .req_o(req_o),
    .data_o(data_o), .gnt_i(gnt_i), .vld_i(vld_i), .rdata_i(rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the negedge; outputs settle before the posedge.
  task automatic drive(input logic [3:0] req, input logic gnt, input logic vld,
                       input logic [31:0] rdata);
    @(negedge clk_i);
    rst_i   = 1'b0;
    req_i   = req;
    gnt_i   = gnt;
    vld_i   = vld;
    rdata_i = rdata;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    req_i = '0;
    gnt_i = 1'b0;
    vld_i = 1'b0;
    rdata_i = '0;
  endtask

  task automatic expect_cycle(input string tag, input logic rq, input logic [3:0] g,
                              input logic [3:0] v);
    check({tag, ".req_o"}, 64'(req_o), 64'(rq));
    check({tag, ".gnt_o"}, 64'(gnt_o), 64'(g));
    check({tag, ".vld_o"}, 64'(vld_o), 64'(v));
  endtask

  initial begin
    for (int j = 0; j < NumIn; j++) data_i[j] = 32'h1000_0000 + 32'(j);

    // Reset state
    do_reset();
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    expect_cycle("rst", 1'b0, 4'b0000, 4'b0000);

    // Alternating m0/m2 with latency-1 responses
    do_reset();
    drive(4'b0101, 1'b1, 1'b0, 32'h0);
    expect_cycle("alt1", 1'b1, 4'b0001, 4'b0000);
    check("alt1.data_o", 64'(data_o), 64'h1000_0000);
    drive(4'b0101, 1'b1, 1'b1, 32'hA5A5_0000);
    expect_cycle("alt2", 1'b1, 4'b0100, 4'b0001);
    check("alt2.data_o", 64'(data_o), 64'h1000_0002);
    check("alt2.rdata0", 64'(rdata_o[0]), 64'hA5A5_0000);
    drive(4'b0101, 1'b1, 1'b1, 32'hA5A5_0002);
    expect_cycle("alt3", 1'b1, 4'b0001, 4'b0100);
    check("alt3.rdata2", 64'(rdata_o[2]), 64'hA5A5_0002);
    drive(4'b0101, 1'b1, 1'b1, 32'hA5A5_0000);
    expect_cycle("alt4", 1'b1, 4'b0100, 4'b0001);
    drive(4'b0000, 1'b1, 1'b1, 32'hA5A5_0002);
    expect_cycle("alt5", 1'b0, 4'b0000, 4'b0100);
    check("alt5.rdata3", 64'(rdata_o[3]), 64'hA5A5_0002);

    // All masters requesting: m0,m1,m2,m3,m0
    do_reset();
    drive(4'b1111, 1'b1, 1'b0, 32'h0);
    expect_cycle("all1", 1'b1, 4'b0001, 4'b0000);
    drive(4'b1111, 1'b1, 1'b1, 32'hA5A5_0000);
    expect_cycle("all2", 1'b1, 4'b0010, 4'b0001);
    drive(4'b1111, 1'b1, 1'b1, 32'hA5A5_0001);
    expect_cycle("all3", 1'b1, 4'b0100, 4'b0010);
    drive(4'b1111, 1'b1, 1'b1, 32'hA5A5_0002);
    expect_cycle("all4", 1'b1, 4'b1000, 4'b0100);
    drive(4'b1111, 1'b1, 1'b1, 32'hA5A5_0003);
    expect_cycle("all5", 1'b1, 4'b0001, 4'b1000);
    drive(4'b0000, 1'b1, 1'b1, 32'hA5A5_0000);
    expect_cycle("all6", 1'b0, 4'b0000, 4'b0001);

    // Outstanding limit: two grants, stall, full+pop re-grant, in-order routing
    do_reset();
    drive(4'b0011, 1'b1, 1'b0, 32'h0);
    expect_cycle("full1", 1'b1, 4'b0001, 4'b0000);
    drive(4'b0011, 1'b1, 1'b0, 32'h0);
    expect_cycle("full2", 1'b1, 4'b0010, 4'b0000);
    for (int c = 3; c <= 5; c++) begin
      drive(4'b0011, 1'b1, 1'b0, 32'h0);
      expect_cycle($sformatf("full%0d", c), 1'b0, 4'b0000, 4'b0000);
    end
    drive(4'b0011, 1'b1, 1'b1, 32'hA5A5_0000);
    expect_cycle("full6", 1'b1, 4'b0001, 4'b0001);
    check("full6.rdata0", 64'(rdata_o[0]), 64'hA5A5_0000);
    drive(4'b0000, 1'b1, 1'b1, 32'hA5A5_0001);
    expect_cycle("full7", 1'b0, 4'b0000, 4'b0010);
    check("full7.rdata1", 64'(rdata_o[1]), 64'hA5A5_0001);
    drive(4'b0000, 1'b1, 1'b1, 32'hA5A5_0000);
    expect_cycle("full8", 1'b0, 4'b0000, 4'b0001);

    // Bank stalls grant: request held, winner m2, pointer then moves to 3
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      drive(4'b0100, 1'b0, 1'b0, 32'h0);
      expect_cycle($sformatf("stall%0d", c), 1'b1, 4'b0000, 4'b0000);
      check($sformatf("stall%0d.data_o", c), 64'(data_o), 64'h1000_0002);
    end
    drive(4'b0100, 1'b1, 1'b0, 32'h0);
    expect_cycle("stall4", 1'b1, 4'b0100, 4'b0000);
    drive(4'b1111, 1'b0, 1'b0, 32'h0);
    expect_cycle("stall5", 1'b1, 4'b0000, 4'b0000);
    check("stall5.data_o", 64'(data_o), 64'h1000_0003);
    drive(4'b0000, 1'b0, 1'b1, 32'hA5A5_0002);
    expect_cycle("stall6", 1'b0, 4'b0000, 4'b0100);

    // Reset with two IDs in flight discards them
    do_reset();
    drive(4'b0011, 1'b1, 1'b0, 32'h0);
    expect_cycle("flush1", 1'b1, 4'b0001, 4'b0000);
    drive(4'b0011, 1'b1, 1'b0, 32'h0);
    expect_cycle("flush2", 1'b1, 4'b0010, 4'b0000);
    do_reset();
    drive(4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF);
    expect_cycle("flush3", 1'b0, 4'b0000, 4'b0000);
    drive(4'b0011, 1'b1, 1'b0, 32'h0);
    expect_cycle("flush4", 1'b1, 4'b0001, 4'b0000);
    drive(4'b0011, 1'b1, 1'b0, 32'h0);
    expect_cycle("flush5", 1'b1, 4'b0010, 4'b0000);
    drive(4'b0011, 1'b1, 1'b0, 32'h0);
    expect_cycle("flush6", 1'b0, 4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
